// File: rtl/pad_out_guard_mux_pkg.sv
// Shared types and defaults for the pad output guard mux.
// Imported by the interface, the timer and the top.
package pad_ctrl_pkg;

    typedef enum logic {
        PAD_GUARD,
        PAD_ACTIVE
    } pad_guard_state_e;

    localparam int PAD_NUM_FUNC_DEF = 4;
    localparam int PAD_ATTR_W_DEF   = 16;
    localparam int PAD_GUARD_DEF    = 4;

    // A one-function mux still needs a 1-bit select field.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pad_out_guard_mux_if.sv
// Function/config/pad bundle between the requester side and the guard mux.
// master drives function data and config; slave is the mux.
interface pad_out_guard_mux_if
    import pad_ctrl_pkg::*;
#(
    parameter int NUM_FUNC = PAD_NUM_FUNC_DEF,
    parameter int PADATTR  = PAD_ATTR_W_DEF
) ();

    localparam int SELW = sel_w(NUM_FUNC);

    logic [NUM_FUNC-1:0] func_out_i;
    logic [NUM_FUNC-1:0] func_oe_i;
    logic                cfg_valid_i;
    logic                cfg_ready_o;
    logic [SELW-1:0]     cfg_sel_i;
    logic [PADATTR-1:0]  cfg_attr_i;
    logic                cfg_err_o;
    logic [SELW-1:0]     cur_sel_o;
    logic                guarding_o;
    logic                pad_out_o;
    logic                pad_oe_o;
    logic [PADATTR-1:0]  pad_attributes_o;

    modport master (
        output func_out_i, func_oe_i,
        output cfg_valid_i, cfg_sel_i, cfg_attr_i,
        input  cfg_ready_o, cfg_err_o, cur_sel_o,
        input  guarding_o, pad_out_o, pad_oe_o,
        input  pad_attributes_o
    );

    modport slave (
        input  func_out_i, func_oe_i,
        input  cfg_valid_i, cfg_sel_i, cfg_attr_i,
        output cfg_ready_o, cfg_err_o, cur_sel_o,
        output guarding_o, pad_out_o, pad_oe_o,
        output pad_attributes_o
    );

endinterface

// File: rtl/pad_out_guard_mux_timer.sv
// Guard-period down-counter; reloads to GUARD_CYCLES-1 and
// flags done once it has counted down to zero.
module pad_guard_timer #(
    parameter int GUARD_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int TW = $clog2(GUARD_CYCLES + 1);
    localparam logic [TW-1:0] LOAD_VAL = TW'(GUARD_CYCLES - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= LOAD_VAL;
        end else if (load_i) begin
            r_cnt <= LOAD_VAL;
        end else if (en_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign done_o = (r_cnt == '0);

endmodule

// File: rtl/pad_out_guard_mux.sv
// Registered function select in front of the pad cell; every function or
// attribute change parks the pad undriven for a guard period first.
module pad_out_guard_mux
    import pad_ctrl_pkg::*;
#(
    parameter int   NUM_FUNC     = PAD_NUM_FUNC_DEF,
    parameter int   PADATTR      = PAD_ATTR_W_DEF,
    parameter int   GUARD_CYCLES = PAD_GUARD_DEF,
    parameter logic SAFE_VALUE   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    pad_out_guard_mux_if.slave bus
);

    localparam int SELW = sel_w(NUM_FUNC);

    pad_guard_state_e   r_state;
    logic [SELW-1:0]    r_sel;
    logic [PADATTR-1:0] r_attr;
    logic               r_pad_out;
    logic               r_pad_oe;
    logic               r_err;

    logic w_guard;
    logic w_accept;
    logic w_bad_sel;
    logic w_same;
    logic w_switch;
    logic w_done;

    assign w_guard   = (r_state == PAD_GUARD);
    assign w_accept  = !w_guard && bus.cfg_valid_i;
    assign w_bad_sel = int'(bus.cfg_sel_i) >= NUM_FUNC;
    assign w_same    = (bus.cfg_sel_i == r_sel) &&
                       (bus.cfg_attr_i == r_attr);
    assign w_switch  = w_accept && !w_bad_sel && !w_same;

    pad_guard_timer #(
        .GUARD_CYCLES(GUARD_CYCLES)
    ) u_timer (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .load_i(w_switch),
        .en_i  (w_guard),
        .done_o(w_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= PAD_GUARD;
            r_sel     <= '0;
            r_attr    <= '0;
            r_pad_out <= SAFE_VALUE;
            r_pad_oe  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && w_bad_sel;
            case (r_state)
                PAD_GUARD: begin
                    r_pad_out <= SAFE_VALUE;
                    r_pad_oe  <= 1'b0;
                    if (w_done) begin
                        r_state <= PAD_ACTIVE;
                    end
                end
                PAD_ACTIVE: begin
                    // New shadows show on the pad side together with the
                    // first safe cycle, so attributes never see glitch data.
                    if (w_switch) begin
                        r_state   <= PAD_GUARD;
                        r_sel     <= bus.cfg_sel_i;
                        r_attr    <= bus.cfg_attr_i;
                        r_pad_out <= SAFE_VALUE;
                        r_pad_oe  <= 1'b0;
                    end else begin
                        r_pad_out <= bus.func_out_i[r_sel];
                        r_pad_oe  <= bus.func_oe_i[r_sel];
                    end
                end
                default: begin
                    r_state <= PAD_GUARD;
                end
            endcase
        end
    end

    assign bus.cfg_ready_o      = (r_state == PAD_ACTIVE);
    assign bus.guarding_o       = w_guard;
    assign bus.cfg_err_o        = r_err;
    assign bus.cur_sel_o        = r_sel;
    assign bus.pad_out_o        = r_pad_out;
    assign bus.pad_oe_o         = r_pad_oe;
    assign bus.pad_attributes_o = r_attr;

endmodule
